// File: rtl/dmem_sort_ctrl.sv
// dmem_sort_ctrl
//   In-place bubble sort sequencer sitting between the CPU load/store path and
//   the word-organised data memory (byte addressed, 32-bit words when B=8).
//   While idle every CPU memory signal passes straight through. While sorting
//   the controller owns both read ports and the write port and raises busy so
//   the CPU stalls. Sorts `count` words starting at `base_addr` into ascending
//   unsigned order and reports the number of swaps in swap_count.
//
//   Optional feature macro: DMEM_SORT_EARLY_EXIT_EN
//     defined   -> a pass that performs no swap ends the sort immediately
//     undefined -> always count-1 full passes
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   start, base_addr, count : sort request (sampled only in IDLE)
//   busy, done, swap_count  : status (done is a one-cycle pulse)
//   cpu_*                   : CPU side of the memory path
//   mem_*                   : memory side of the memory path
module dmem_sort_ctrl #(
  parameter int B = 8,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   base_addr,
  input  logic [N-1:0]   count,
  output logic           busy,
  output logic           done,
  output logic [15:0]    swap_count,
  input  logic [N-1:0]   cpu_r_addr1,
  input  logic [N-1:0]   cpu_r_addr2,
  input  logic [N-1:0]   cpu_w_addr,
  input  logic [4*B-1:0] cpu_w_data,
  input  logic           cpu_write_en,
  input  logic           cpu_read_en,
  output logic [N-1:0]   mem_r_addr1,
  output logic [N-1:0]   mem_r_addr2,
  output logic [N-1:0]   mem_w_addr,
  output logic [4*B-1:0] mem_w_data,
  output logic           mem_write_en,
  output logic           mem_read_en,
  input  logic [4*B-1:0] mem_r_data1,
  input  logic [4*B-1:0] mem_r_data2,
  output logic [4*B-1:0] cpu_r_data1,
  output logic [4*B-1:0] cpu_r_data2
);

  localparam int W = 4 * B;

  typedef enum logic [2:0] {IDLE, CMP, WR_LO, WR_HI, FIN} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   base_q, lim_q, j_q;
  logic [W-1:0]   wa_q, wb_q;
  logic [15:0]    swap_q;

  logic [N-1:0]   addr_lo, addr_hi;
  logic [N:0]     j_inc;
  logic           gt, adv, more_j, more_pass, stop_early;
  state_t         adv_nx;

  // Word pair under inspection; address math wraps modulo 2^N like the memory.
  assign addr_lo   = base_q + (j_q << 2);
  assign addr_hi   = addr_lo + N'(4);
  assign gt        = mem_r_data1 > mem_r_data2;
  assign adv       = (state == CMP && !gt) || (state == WR_HI);
  // Extra bit keeps j+1 from wrapping when lim is near the top of the range.
  assign j_inc     = {1'b0, j_q} + {{N{1'b0}}, 1'b1};
  assign more_j    = j_inc < {1'b0, lim_q};
  assign more_pass = lim_q > N'(1);

`ifdef DMEM_SORT_EARLY_EXIT_EN
  logic swapped_q;
  // The WR_HI of the final step counts as a swap for this pass.
  assign stop_early = !(swapped_q || state == WR_HI);
`else
  assign stop_early = 1'b0;
`endif

  // Where an advance leads: next compare in this pass, next pass, or done.
  always_comb begin
    adv_nx = FIN;
    if (more_j)                       adv_nx = CMP;
    else if (more_pass && !stop_early) adv_nx = CMP;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (count < N'(2)) ? FIN : CMP;
      CMP:     state_nx = gt ? WR_LO : adv_nx;
      WR_LO:   state_nx = WR_HI;
      WR_HI:   state_nx = adv_nx;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      lim_q  <= '0;
      j_q    <= '0;
      wa_q   <= '0;
      wb_q   <= '0;
      swap_q <= '0;
`ifdef DMEM_SORT_EARLY_EXIT_EN
      swapped_q <= 1'b0;
`endif
    end else begin
      if (state == IDLE && start) begin
        base_q <= base_addr;
        lim_q  <= count - N'(1);
        j_q    <= '0;
        swap_q <= '0;
`ifdef DMEM_SORT_EARLY_EXIT_EN
        swapped_q <= 1'b0;
`endif
      end
      if (state == CMP && gt) begin
        wa_q <= mem_r_data1;
        wb_q <= mem_r_data2;
      end
      if (state == WR_HI) begin
        if (swap_q != 16'hFFFF) swap_q <= swap_q + 16'd1;
`ifdef DMEM_SORT_EARLY_EXIT_EN
        swapped_q <= 1'b1;
`endif
      end
      if (adv) begin
        if (more_j) begin
          j_q <= j_inc[N-1:0];
        end else begin
          // Pass boundary; lim also decrements on the way to FIN, which is harmless.
          j_q   <= '0;
          lim_q <= lim_q - N'(1);
`ifdef DMEM_SORT_EARLY_EXIT_EN
          swapped_q <= 1'b0;
`endif
        end
      end
    end
  end

  // Outputs and memory ownership mux
  always_comb begin
    busy         = (state == CMP) || (state == WR_LO) || (state == WR_HI);
    done         = (state == FIN);
    swap_count   = swap_q;
    cpu_r_data1  = mem_r_data1;
    cpu_r_data2  = mem_r_data2;
    mem_r_addr1  = cpu_r_addr1;
    mem_r_addr2  = cpu_r_addr2;
    mem_w_addr   = cpu_w_addr;
    mem_w_data   = cpu_w_data;
    mem_write_en = cpu_write_en;
    mem_read_en  = cpu_read_en;
    if (busy) begin
      // CPU strobes are dropped, not queued, while the sorter owns memory.
      mem_r_addr1  = addr_lo;
      mem_r_addr2  = addr_hi;
      mem_read_en  = (state == CMP);
      mem_w_addr   = (state == WR_HI) ? addr_hi : addr_lo;
      mem_w_data   = (state == WR_HI) ? wa_q : wb_q;
      mem_write_en = (state == WR_LO) || (state == WR_HI);
    end
    // No write may reach memory in a reset cycle, pass-through included.
    if (rst) mem_write_en = 1'b0;
  end

endmodule
